// File: rtl/issue_exec_unit.sv
// Two-stage integer execute unit: S1 captures operands, S2 holds the result until the CDB grants it.
// Optional operand forwarding from the CDB is compiled in with EXEC_CDB_BYPASS_EN.
module issue_exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PTAG_W = 6,
  parameter int unsigned ROB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [XLEN-1:0]   iss_pc,
  input  logic [XLEN-1:0]   iss_imm,
  input  logic [3:0]        iss_alu_op,
  input  logic              iss_alu_src,
  input  logic [PTAG_W-1:0] iss_p_src1,
  input  logic [PTAG_W-1:0] iss_p_src2,
  input  logic [PTAG_W-1:0] iss_p_dst,
  input  logic [ROB_W-1:0]  iss_rob_tag,
  input  logic              iss_is_branch,
  input  logic              iss_is_jump,
  output logic [PTAG_W-1:0] prf_raddr1,
  output logic [PTAG_W-1:0] prf_raddr2,
  input  logic [XLEN-1:0]   prf_rdata1,
  input  logic [XLEN-1:0]   prf_rdata2,
  output logic              cdb_valid,
  output logic [PTAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]   cdb_data,
  output logic [ROB_W-1:0]  cdb_rob_tag,
  input  logic              cdb_grant,
  output logic              br_valid,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_target,
  output logic [ROB_W-1:0]  br_rob_tag
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_BGE  = 4'd13;
  localparam logic [3:0] OP_BGEU = 4'd14;

  logic              r_s1_valid;
  logic [XLEN-1:0]   r_s1_pc;
  logic [XLEN-1:0]   r_s1_imm;
  logic [3:0]        r_s1_op;
  logic              r_s1_alu_src;
  logic [PTAG_W-1:0] r_s1_dst;
  logic [ROB_W-1:0]  r_s1_rob;
  logic              r_s1_br;
  logic              r_s1_jmp;
  logic [XLEN-1:0]   r_s1_src1;
  logic [XLEN-1:0]   r_s1_src2;

  logic              w_s1_adv;
  logic              w_accept;
  logic [XLEN-1:0]   w_cap1;
  logic [XLEN-1:0]   w_cap2;
  logic [XLEN-1:0]   w_src1;
  logic [XLEN-1:0]   w_src2;
  logic [XLEN-1:0]   w_b;
  logic [4:0]        w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_result;
  logic              w_cmp_taken;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;

  // S2 empties when nothing is pending or the pending broadcast is granted; S1 follows S2.
  assign w_s1_adv   = !cdb_valid || cdb_grant;
  assign iss_ready  = (!r_s1_valid || w_s1_adv) && !flush;
  assign w_accept   = iss_valid && iss_ready;
  assign prf_raddr1 = iss_p_src1;
  assign prf_raddr2 = iss_p_src2;

`ifdef EXEC_CDB_BYPASS_EN
  logic [PTAG_W-1:0] r_s1_tag1;
  logic [PTAG_W-1:0] r_s1_tag2;
  logic              w_cdb_fire;

  // A granted broadcast overrides stale PRF data both at capture and while waiting in S1.
  assign w_cdb_fire = cdb_valid && cdb_grant;
  assign w_cap1 = (w_cdb_fire && (cdb_tag == iss_p_src1)) ? cdb_data : prf_rdata1;
  assign w_cap2 = (w_cdb_fire && (cdb_tag == iss_p_src2)) ? cdb_data : prf_rdata2;
  assign w_src1 = (w_cdb_fire && (cdb_tag == r_s1_tag1))  ? cdb_data : r_s1_src1;
  assign w_src2 = (w_cdb_fire && (cdb_tag == r_s1_tag2))  ? cdb_data : r_s1_src2;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_tag1 <= iss_p_src1;
      r_s1_tag2 <= iss_p_src2;
    end
  end
`else
  assign w_cap1 = prf_rdata1;
  assign w_cap2 = prf_rdata2;
  assign w_src1 = r_s1_src1;
  assign w_src2 = r_s1_src2;
`endif

  // Execute: ALU, branch compare and target generation from S1 operands.
  always_comb begin
    w_b         = r_s1_alu_src ? r_s1_imm : w_src2;
    w_shamt     = w_b[4:0];
    w_alu       = '0;
    w_cmp_taken = 1'b0;
    unique case (r_s1_op)
      OP_ADD:  w_alu = w_src1 + w_b;
      OP_SUB:  w_alu = w_src1 - w_b;
      OP_AND:  w_alu = w_src1 & w_b;
      OP_OR:   w_alu = w_src1 | w_b;
      OP_XOR:  w_alu = w_src1 ^ w_b;
      OP_SLL:  w_alu = w_src1 << w_shamt;
      OP_SRL:  w_alu = w_src1 >> w_shamt;
      OP_SRA:  w_alu = XLEN'($signed(w_src1) >>> w_shamt);
      OP_SLT:  w_alu = XLEN'($signed(w_src1) < $signed(w_b));
      OP_SLTU: w_alu = XLEN'(w_src1 < w_b);
      OP_LUI:  w_alu = r_s1_imm;
      default: w_alu = '0;
    endcase
    unique case (r_s1_op)
      OP_BEQ:  w_cmp_taken = (w_src1 == w_src2);
      OP_BNE:  w_cmp_taken = (w_src1 != w_src2);
      OP_SLT:  w_cmp_taken = ($signed(w_src1) < $signed(w_src2));
      OP_SLTU: w_cmp_taken = (w_src1 < w_src2);
      OP_BGE:  w_cmp_taken = ($signed(w_src1) >= $signed(w_src2));
      OP_BGEU: w_cmp_taken = (w_src1 >= w_src2);
      default: w_cmp_taken = 1'b0;
    endcase
    w_result = r_s1_jmp ? (r_s1_pc + XLEN'(4)) : w_alu;
    w_taken  = r_s1_jmp || w_cmp_taken;
    w_target = (r_s1_jmp && r_s1_alu_src) ? ((w_src1 + r_s1_imm) & ~XLEN'(1))
                                          : (r_s1_pc + r_s1_imm);
  end

  // Pipeline valid bits; br_valid is a single-cycle pulse on S2 entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      cdb_valid  <= 1'b0;
      br_valid   <= 1'b0;
    end else begin
      br_valid <= 1'b0;
      if (flush) begin
        r_s1_valid <= 1'b0;
        cdb_valid  <= 1'b0;
      end else begin
        if (w_s1_adv) begin
          cdb_valid <= r_s1_valid && !r_s1_br;
          br_valid  <= r_s1_valid && (r_s1_br || r_s1_jmp);
        end
        if (w_accept) begin
          r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
          r_s1_valid <= 1'b0;
        end
      end
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_pc      <= iss_pc;
      r_s1_imm     <= iss_imm;
      r_s1_op      <= iss_alu_op;
      r_s1_alu_src <= iss_alu_src;
      r_s1_dst     <= iss_p_dst;
      r_s1_rob     <= iss_rob_tag;
      r_s1_br      <= iss_is_branch;
      r_s1_jmp     <= iss_is_jump;
      r_s1_src1    <= w_cap1;
      r_s1_src2    <= w_cap2;
    end else begin
      r_s1_src1    <= w_src1;
      r_s1_src2    <= w_src2;
    end
    if (w_s1_adv && r_s1_valid) begin
      cdb_tag     <= r_s1_dst;
      cdb_data    <= w_result;
      cdb_rob_tag <= r_s1_rob;
      br_taken    <= w_taken;
      br_target   <= w_target;
      br_rob_tag  <= r_s1_rob;
    end
  end

endmodule

// File: tb/tb_issue_exec_unit.sv
// Scoreboard bench for issue_exec_unit: directed cases plus randomized traffic against a spec-level model.
module tb_issue_exec_unit;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic [3:0]  rob;
  } cdb_exp_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [3:0]  rob;
  } br_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [31:0] iss_pc = '0;
  logic [31:0] iss_imm = '0;
  logic [3:0]  iss_alu_op = '0;
  logic        iss_alu_src = 1'b0;
  logic [5:0]  iss_p_src1 = '0;
  logic [5:0]  iss_p_src2 = '0;
  logic [5:0]  iss_p_dst = '0;
  logic [3:0]  iss_rob_tag = '0;
  logic        iss_is_branch = 1'b0;
  logic        iss_is_jump = 1'b0;
  logic [5:0]  prf_raddr1, prf_raddr2;
  logic [31:0] prf_rdata1, prf_rdata2;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_rob_tag;
  logic        cdb_grant = 1'b1;
  logic        br_valid, br_taken;
  logic [31:0] br_target;
  logic [3:0]  br_rob_tag;

  logic [31:0] prf [64];
  cdb_exp_t    cdbq[$];
  br_exp_t     brq[$];
  int          errors = 0;
  int          checks = 0;

  assign prf_rdata1 = prf[prf_raddr1];
  assign prf_rdata2 = prf[prf_raddr2];

  always #5 clk = ~clk;

  issue_exec_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_alu_op(iss_alu_op), .iss_alu_src(iss_alu_src),
    .iss_p_src1(iss_p_src1), .iss_p_src2(iss_p_src2), .iss_p_dst(iss_p_dst),
    .iss_rob_tag(iss_rob_tag), .iss_is_branch(iss_is_branch), .iss_is_jump(iss_is_jump),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_rob_tag(cdb_rob_tag),
    .cdb_grant(cdb_grant),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .br_rob_tag(br_rob_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour written straight from the operation table.
  function automatic void model(input logic [3:0] op, input bit asrc, input bit br, input bit jmp,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] s2,
                                output logic [31:0] d, output bit tk, output logic [31:0] tg);
    logic [31:0] b;
    b = asrc ? imm : s2;
    case (op)
      4'd0:  d = a + b;
      4'd1:  d = a - b;
      4'd2:  d = a & b;
      4'd3:  d = a | b;
      4'd4:  d = a ^ b;
      4'd5:  d = a << b[4:0];
      4'd6:  d = a >> b[4:0];
      4'd7:  d = 32'($signed(a) >>> b[4:0]);
      4'd8:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  d = (a < b) ? 32'd1 : 32'd0;
      4'd10: d = imm;
      default: d = 32'd0;
    endcase
    tk = 1'b0;
    tg = pc + imm;
    if (br) begin
      case (op)
        4'd11: tk = (a == s2);
        4'd12: tk = (a != s2);
        4'd8:  tk = ($signed(a) < $signed(s2));
        4'd9:  tk = (a < s2);
        4'd13: tk = ($signed(a) >= $signed(s2));
        4'd14: tk = (a >= s2);
        default: tk = 1'b0;
      endcase
    end
    if (jmp) begin
      d  = pc + 32'd4;
      tk = 1'b1;
      if (asrc) tg = (a + imm) & 32'hFFFF_FFFE;
    end
  endfunction

  // One clock: decide acceptance before the edge, record expectations, drop them on flush.
  task automatic tick(input bit use_exp, input logic [31:0] ed, input bit et,
                      input logic [31:0] etg, output bit acc);
    logic [31:0] d, tg;
    bit tk;
    @(negedge clk);
    acc = iss_valid && iss_ready;
    if (flush) chk("ready_during_flush", 64'(iss_ready), 64'd0);
    if (acc) begin
      if (use_exp) begin
        d = ed; tk = et; tg = etg;
      end else begin
        model(iss_alu_op, iss_alu_src, iss_is_branch, iss_is_jump, iss_pc, iss_imm,
              prf[iss_p_src1], prf[iss_p_src2], d, tk, tg);
      end
      if (!iss_is_branch) cdbq.push_back('{tag: iss_p_dst, data: d, rob: iss_rob_tag});
      if (iss_is_branch || iss_is_jump) brq.push_back('{taken: tk, target: tg, rob: iss_rob_tag});
    end
    @(posedge clk);
    #1;
    if (flush) begin
      cdbq.delete();
      brq.delete();
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0, 32'd0, acc);
  endtask

  task automatic issue(input logic [3:0] op, input bit asrc, input bit br, input bit jmp,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] dst,
                       input logic [3:0] rob, input logic [31:0] ed, input bit et,
                       input logic [31:0] etg);
    bit acc;
    acc = 1'b0;
    iss_valid = 1'b1; iss_alu_op = op; iss_alu_src = asrc; iss_is_branch = br; iss_is_jump = jmp;
    iss_pc = pc; iss_imm = imm; iss_p_src1 = s1; iss_p_src2 = s2; iss_p_dst = dst; iss_rob_tag = rob;
    for (int i = 0; i < 20 && !acc; i++) tick(1'b1, ed, et, etg, acc);
    iss_valid = 1'b0;
    chk("issue_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    iss_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b1;
    n = 0;
    while ((cdbq.size() != 0 || brq.size() != 0 || cdb_valid) && n < 60) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_pending", 64'(cdbq.size() + brq.size()), 64'd0);
  endtask

  // Monitor: pops on every granted broadcast and every branch pulse; checks hold stability.
  bit       hold_pend = 1'b0;
  bit       prev_flush = 1'b0;
  cdb_exp_t held;
  always @(negedge clk) begin
    cdb_exp_t e;
    br_exp_t  b;
    if (reset) begin
      hold_pend  = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_flush) hold_pend = 1'b0;
      if (hold_pend) begin
        chk("cdb_hold_valid", 64'(cdb_valid), 64'd1);
        chk("cdb_hold_payload", 64'({cdb_tag, cdb_data, cdb_rob_tag}), 64'(held));
      end
      if (cdb_valid && cdb_grant) begin
        if (cdbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cdb_unexpected: tag %0d data 0x%0h with nothing expected", cdb_tag, cdb_data);
        end else begin
          e = cdbq.pop_front();
          chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
          chk("cdb_data", 64'(cdb_data), 64'(e.data));
          chk("cdb_rob_tag", 64'(cdb_rob_tag), 64'(e.rob));
        end
      end
      if (br_valid) begin
        if (brq.size() == 0) begin
          checks++; errors++;
          $display("FAIL br_unexpected: target 0x%0h with nothing expected", br_target);
        end else begin
          b = brq.pop_front();
          chk("br_taken", 64'(br_taken), 64'(b.taken));
          chk("br_target", 64'(br_target), 64'(b.target));
          chk("br_rob_tag", 64'(br_rob_tag), 64'(b.rob));
        end
      end
      hold_pend  = cdb_valid && !cdb_grant;
      held       = '{tag: cdb_tag, data: cdb_data, rob: cdb_rob_tag};
      prev_flush = flush;
    end
  end

  initial begin
    bit acc;
    int r;
    for (int i = 0; i < 64; i++) prf[i] = $urandom;
    prf[0] = 32'h0; prf[1] = 32'hFFFF_FFFF; prf[2] = 32'h8000_0000; prf[3] = 32'h1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_br_valid", 64'(br_valid), 64'd0);
    chk("reset_iss_ready", 64'(iss_ready), 64'd1);

    // ADD with minimum latency
    prf[5] = 32'd5; prf[7] = 32'd7;
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd5, 6'd7, 6'd9, 4'd3, 32'd12, 0, 32'd0);
    chk("lat_n1_cdb_valid", 64'(cdb_valid), 64'd0);
    idle(1);
    chk("lat_n2_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("lat_n2_cdb_data", 64'(cdb_data), 64'd12);
    drain();

    // Wraparound, arithmetic shift and unsigned compare edges
    prf[10] = 32'h0; prf[11] = 32'h1; prf[12] = 32'h8000_0000; prf[13] = 32'hFFFF_FFFF;
    issue(4'd1, 0, 0, 0, 32'h0, 32'h0, 6'd10, 6'd11, 6'd20, 4'd1, 32'hFFFF_FFFF, 0, 32'd0);
    issue(4'd7, 1, 0, 0, 32'h0, 32'h4, 6'd12, 6'd0, 6'd21, 4'd2, 32'hF800_0000, 0, 32'd0);
    issue(4'd9, 0, 0, 0, 32'h0, 32'h0, 6'd11, 6'd13, 6'd22, 4'd4, 32'd1, 0, 32'd0);
    issue(4'd10, 1, 0, 0, 32'h0, 32'h1234_5000, 6'd0, 6'd0, 6'd23, 4'd5, 32'h1234_5000, 0, 32'd0);
    drain();

    // Backpressure: no grant for three cycles with three back-to-back ADDs
    prf[1] = 32'd100; prf[2] = 32'd23;
    cdb_grant = 1'b0;
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd1, 6'd2, 6'd50, 4'd6, 32'd123, 0, 32'd0);
    issue(4'd0, 1, 0, 0, 32'h0, 32'd7, 6'd1, 6'd2, 6'd51, 4'd7, 32'd107, 0, 32'd0);
    iss_valid = 1'b1; iss_alu_src = 1'b1; iss_imm = 32'd9; iss_p_dst = 6'd52; iss_rob_tag = 4'd8;
    tick(1'b1, 32'd109, 1'b0, 32'd0, acc);
    chk("full_ready_drop", 64'(acc), 64'd0);
    tick(1'b1, 32'd109, 1'b0, 32'd0, acc);
    chk("full_ready_hold", 64'(acc), 64'd0);
    tick(1'b1, 32'd109, 1'b0, 32'd0, acc);
    chk("full_ready_hold2", 64'(acc), 64'd0);
    cdb_grant = 1'b1;
    issue(4'd0, 1, 0, 0, 32'h0, 32'd9, 6'd1, 6'd2, 6'd52, 4'd8, 32'd109, 0, 32'd0);
    drain();

    // Branch resolves without a CDB request; JALR clears bit 0 and links pc+4
    prf[14] = 32'd4; prf[15] = 32'd4; prf[16] = 32'h203;
    issue(4'd11, 0, 1, 0, 32'h100, 32'h20, 6'd14, 6'd15, 6'd24, 4'd9, 32'd0, 1, 32'h120);
    idle(1);
    chk("beq_br_valid", 64'(br_valid), 64'd1);
    chk("beq_no_cdb", 64'(cdb_valid), 64'd0);
    idle(1);
    chk("beq_pulse_once", 64'(br_valid), 64'd0);
    issue(4'd0, 1, 0, 1, 32'h300, 32'h0, 6'd16, 6'd0, 6'd25, 4'd10, 32'h304, 1, 32'h202);
    drain();

    // Flush with both stages occupied; the packet offered alongside must be dropped
    cdb_grant = 1'b0;
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd5, 6'd7, 6'd26, 4'd11, 32'd12, 0, 32'd0);
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd7, 6'd7, 6'd27, 4'd12, 32'd14, 0, 32'd0);
    flush = 1'b1; iss_valid = 1'b1; iss_p_dst = 6'd28;
    tick(1'b1, 32'd0, 1'b0, 32'd0, acc);
    chk("flush_no_accept", 64'(acc), 64'd0);
    flush = 1'b0; iss_valid = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_br_valid", 64'(br_valid), 64'd0);
    cdb_grant = 1'b1;
    idle(6);
    drain();

`ifdef EXEC_CDB_BYPASS_EN
    // Consumer waits in S1 with a stale PRF value while its producer broadcasts
    prf[5] = 32'h0; prf[40] = 32'h50; prf[41] = 32'h05; prf[42] = 32'h0;
    cdb_grant = 1'b0;
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd40, 6'd41, 6'd5, 4'd13, 32'h55, 0, 32'd0);
    issue(4'd0, 0, 0, 0, 32'h0, 32'h0, 6'd5, 6'd42, 6'd43, 4'd14, 32'h55, 0, 32'd0);
    idle(1);
    cdb_grant = 1'b1;
    drain();
`endif

    // Randomized traffic: sources 0..31, destinations 32..63, so no forwarding paths fire
    for (int c = 0; c < 800; c++) begin
      iss_valid     = ($urandom_range(0, 9) < 7);
      iss_alu_op    = 4'($urandom_range(0, 15));
      iss_alu_src   = 1'($urandom_range(0, 1));
      r             = $urandom_range(0, 9);
      iss_is_branch = (r < 2);
      iss_is_jump   = (r == 2);
      iss_pc        = $urandom;
      iss_imm       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      iss_p_src1    = 6'($urandom_range(0, 31));
      iss_p_src2    = 6'($urandom_range(0, 31));
      iss_p_dst     = 6'($urandom_range(32, 63));
      iss_rob_tag   = 4'($urandom_range(0, 15));
      cdb_grant     = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 59) == 0);
      tick(1'b0, 32'd0, 1'b0, 32'd0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_exec_unit.md
ISSUE_EXEC_UNIT -- requirements
Module: issue_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter PTAG_W, default 6, physical-register tag width (64 physical registers).
REQ-003 Parameter ROB_W, default 4, ROB tag width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  mispredict squash; kills all in-flight ops.
REQ-007 iss_valid  in  1  issue packet from reservation station is valid.
REQ-008 iss_ready  out  1  unit accepts the packet this cycle.
REQ-009 iss_pc, iss_imm  in  XLEN each  instruction PC and immediate.
REQ-010 iss_alu_op  in  4  operation code; iss_alu_src  in  1  1 = operand B is iss_imm.
REQ-011 iss_p_src1, iss_p_src2, iss_p_dst  in  PTAG_W each  physical tags.
REQ-012 iss_rob_tag  in  ROB_W; iss_is_branch, iss_is_jump  in  1 each.
REQ-013 prf_raddr1, prf_raddr2  out  PTAG_W; prf_rdata1, prf_rdata2  in  XLEN  combinational PRF read.
REQ-014 cdb_valid  out  1; cdb_tag  out  PTAG_W; cdb_data  out  XLEN; cdb_rob_tag  out  ROB_W  result broadcast request.
REQ-015 cdb_grant  in  1  CDB arbiter accepts the current broadcast.
REQ-016 br_valid  out  1; br_taken  out  1; br_target  out  XLEN; br_rob_tag  out  ROB_W  branch/jump resolution, one-cycle pulse.

Function
REQ-017 Pipeline: S1 (operand read/capture), S2 (execute, output register held until granted); each stage has a valid bit.
REQ-018 Packet accepted when iss_valid && iss_ready; prf_raddr1/2 driven combinationally from iss_p_src1/2; S1 captures prf_rdata1/2.
REQ-019 Min latency: accept in cycle N -> cdb_valid in cycle N+2.
REQ-020 S2 retires when !cdb_valid || cdb_grant; S1 advances when S2 retires or S2 empty; iss_ready = (!S1 valid || S1 advances) && !flush.
REQ-021 cdb_valid and all cdb_* held stable while cdb_valid && !cdb_grant.
REQ-022 Operand A = src1; operand B = iss_alu_src ? imm : src2.
REQ-023 alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift = B[4:0]), 8 SLT, 9 SLTU (result 0/1), 10 LUI (result = imm); others result 0; wraparound arithmetic modulo 2^XLEN.
REQ-024 is_branch: no CDB request; taken per alu_op 11 BEQ, 12 BNE, 8 BLT, 9 BLTU, 13 BGE, 14 BGEU on src1/src2; target = pc+imm.
REQ-025 is_jump: cdb_data = pc+4, br_taken=1; target = alu_src ? (src1+imm) with bit0 cleared : pc+imm.
REQ-026 br_valid pulses exactly once, in the cycle the op enters S2, independent of cdb_grant.
REQ-027 flush: S1, S2 valid cleared at that edge; cdb_valid=0 and br_valid=0 next cycle; packet offered during flush is not accepted.
REQ-028 Full pipe (S1, S2 valid, no grant): iss_ready=0, no state change except operand bypass per REQ-032.

Reset
REQ-029 reset clears S1/S2 valid; cdb_valid=0, br_valid=0, iss_ready=1 in the first cycle after reset release.
REQ-030 Reset mid-operation discards all in-flight ops; data registers need not be reset.

Configuration
REQ-031 Macro EXEC_CDB_BYPASS_EN compiles in operand forwarding.
REQ-032 With it: on capture and while in S1, an operand whose tag equals cdb_tag while cdb_valid && cdb_grant takes cdb_data; without it: operands come solely from PRF (PRF must be write-through).

Verification
REQ-033 ADD p1=5, p2=7, dst=9, rob=3 -> two cycles later cdb_valid, tag 9, data 12, rob_tag 3.
REQ-034 SUB 0-1 -> data 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1.
REQ-035 cdb_grant held 0 for 3 cycles, 3 back-to-back ADDs -> outputs stable, iss_ready drops after 2 accepts, all 3 broadcast in order once granted.
REQ-036 BEQ 4==4, pc 0x100, imm 0x20 -> br_valid pulse, taken 1, target 0x120, no cdb_valid; JALR src1 0x203, imm 0 -> target 0x202, data pc+4.
REQ-037 flush with S1 and S2 full -> next cycle cdb_valid=0, br_valid=0, nothing broadcast later.
REQ-038 With EXEC_CDB_BYPASS_EN: op in S1 waiting on tag 5 stale PRF value 0, CDB grants tag 5 data 0x55 -> result uses 0x55.
